pwm_cap: RTL

PWM_CAP -- requirements
Module: pwm_cap

---
 rtl/pwm_cap.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pwm_cap.sv
// PWM period / high-time capture: synchronised input, prescaled tick counter, four-state measurement FSM.
// Optional build macro PWM_CAP_GLITCH_FILTER_EN adds a 3-sample stability filter ahead of edge detection.
module pwm_cap #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 capie_i,
    input  logic                 ovie_i,
    input  logic [CNT_WIDTH-1:0] pscr_i,
    input  logic                 stat_clr_i,
    input  logic                 pwm_i,
    output logic [CNT_WIDTH-1:0] per_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 vld_o,
    output logic                 ovif_o,
    output logic                 irq_o
);

    // state | meaning
    // IDLE  | capture disabled, results held
    // ARM   | waiting for the first rise of a measurement
    // HIGH  | counting the high phase
    // LOW   | counting the low phase; next rise completes a period
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

    state_t state, state_nxt;

    logic sync1, sync2, lvl, lvl_q;
    logic rise, fall;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            sync1 <= pwm_i;
            sync2 <= sync1;
            lvl_q <= lvl;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic [1:0] hist;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) hist <= 2'b00;
        else          hist <= {hist[0], sync2};
    end

    // A new level is only accepted once three consecutive samples agree.
    assign lvl = ((sync2 == hist[0]) && (sync2 == hist[1])) ? sync2 : lvl_q;
`else
    assign lvl = sync2;
`endif

    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

    logic [CNT_WIDTH-1:0] psc, cnt, high_hold;
    logic [CNT_WIDTH-1:0] eff_m1, cnt_tick;
    logic                 counting, tick, cnt_ovf;

    // Compared with >= so a lowered pscr_i takes effect at the next wrap.
    assign eff_m1   = (pscr_i < TWO) ? ONE : (pscr_i - ONE);
    assign counting = (state == HIGH) || (state == LOW);
    assign tick     = counting && (psc >= eff_m1);
    assign cnt_ovf  = tick && (cnt == '1);
    assign cnt_tick = tick ? (cnt + ONE) : cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en_i) begin
            state_nxt = IDLE;
        end else if (clr_i) begin
            state_nxt = ARM;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM:  if (rise) state_nxt = HIGH;
                HIGH: if (cnt_ovf) state_nxt = ARM;
                      else if (fall) state_nxt = LOW;
                LOW:  if (cnt_ovf) state_nxt = ARM;
                      else if (rise) state_nxt = HIGH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic active, do_capture, do_latch_high, do_ovf;

    always_comb begin
        active        = en_i && !clr_i;
        do_ovf        = active && cnt_ovf;
        do_latch_high = active && !cnt_ovf && (state == HIGH) && fall;
        do_capture    = active && !cnt_ovf && (state == LOW) && rise;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            psc <= '0;
            cnt <= '0;
        end else if (!en_i || clr_i || rise) begin
            psc <= '0;
            cnt <= '0;
        end else if (counting) begin
            if (cnt_ovf) begin
                psc <= '0;
            end else if (tick) begin
                psc <= '0;
                cnt <= cnt_tick;
            end else begin
                psc <= psc + ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            high_hold <= '0;
            per_o     <= '0;
            high_o    <= '0;
        end else begin
            if (do_latch_high) high_hold <= cnt_tick;
            if (do_capture) begin
                per_o  <= cnt_tick;
                high_o <= high_hold;
            end
        end
    end

    // Setting a flag wins over a simultaneous stat_clr_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_o  <= 1'b0;
            ovif_o <= 1'b0;
        end else begin
            if (do_capture)      vld_o <= 1'b1;
            else if (stat_clr_i) vld_o <= 1'b0;
            if (do_ovf)          ovif_o <= 1'b1;
            else if (stat_clr_i) ovif_o <= 1'b0;
        end
    end

    assign irq_o = (vld_o & capie_i) | (ovif_o & ovie_i);

endmodule
